// File: rtl/button_event_decoder_pkg.sv
// ---------------------------------------------------------------------------
// button_event_decoder_pkg
// Shared definitions for the button event decoder and for the configuration
// FSM that decodes active_key.
//   state_t : decoder FSM encoding (IDLE, HOLD, REPEAT, WAIT_REL)
//   key_t   : tracked-key codes driven on active_key (KEY_NONE..KEY_IZQDA)
//   pick_key   : fixed-priority encoder, dism > aument > derec > izqda
//   key_onehot : key code to {izqda, derec, aument, dism} one-hot mask
// ---------------------------------------------------------------------------
package button_event_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        REPEAT   = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        KEY_NONE   = 3'd0,
        KEY_DISM   = 3'd1,
        KEY_AUMENT = 3'd2,
        KEY_DEREC  = 3'd3,
        KEY_IZQDA  = 3'd4
    } key_t;

    localparam int NUM_KEYS = 4;

    // lvl bit order: bit0 dism, bit1 aument, bit2 derec, bit3 izqda.
    function automatic key_t pick_key(input logic [NUM_KEYS-1:0] lvl);
        key_t k;
        if (lvl[0])      k = KEY_DISM;
        else if (lvl[1]) k = KEY_AUMENT;
        else if (lvl[2]) k = KEY_DEREC;
        else if (lvl[3]) k = KEY_IZQDA;
        else             k = KEY_NONE;
        return k;
    endfunction

    function automatic logic [NUM_KEYS-1:0] key_onehot(input key_t k);
        logic [NUM_KEYS-1:0] m;
        case (k)
            KEY_DISM:   m = 4'b0001;
            KEY_AUMENT: m = 4'b0010;
            KEY_DEREC:  m = 4'b0100;
            KEY_IZQDA:  m = 4'b1000;
            default:    m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/button_event_decoder_edge_pulse.sv
// ---------------------------------------------------------------------------
// button_event_decoder_edge_pulse
// Registered rising-edge detector: pulse is high for one cycle, the cycle
// after lvl is first sampled high. A level held high gives a single pulse.
// The history register resets to 0, so a level already high when reset is
// released counts as a rising edge.
//   clk       in  system clock
//   btn_reset in  synchronous, active-low reset
//   lvl       in  debounced level
//   pulse     out one-cycle registered pulse
// ---------------------------------------------------------------------------
module button_event_decoder_edge_pulse (
    input  logic clk,
    input  logic btn_reset,
    input  logic lvl,
    output logic pulse
);

    logic lvl_prev;

    always_ff @(posedge clk) begin
        if (!btn_reset) begin
            lvl_prev <= 1'b0;
            pulse    <= 1'b0;
        end else begin
            lvl_prev <= lvl;
            pulse    <= lvl & ~lvl_prev;
        end
    end

endmodule

// File: rtl/button_event_decoder.sv
// ---------------------------------------------------------------------------
// button_event_decoder
// Turns debounced key levels into single-cycle command pulses for the RTC
// configuration/write FSM. Navigation keys pulse once per press, with
// auto-repeat while held for keys enabled in REPEAT_MASK. The write button
// pulses once per press regardless of enable or the navigation FSM.
//   clk        in  system clock
//   btn_reset  in  synchronous, active-low reset
//   enable     in  decoder enable; low suppresses navigation pulses
//   dism_lvl, aument_lvl, derec_lvl, izqda_lvl in  key levels, high = pressed
//   escrib_lvl in  write-button level
//   dism_p, aument_p, derec_p, izqda_p out  one-cycle navigation pulses
//   escrib_p   out one-cycle write pulse
//   active_key out tracked key code (key_t)
//   fsm_state  out current FSM state, for observation only
//
// Handshake: there is none; every pulse is a one-cycle strobe the consumer
// must sample on the cycle it is high, and no backpressure exists.
// ---------------------------------------------------------------------------
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int         HOLD_CYCLES   = 50000000,
    parameter int         REPEAT_CYCLES = 20000000,
    parameter int         CNT_W         = 26,
    parameter logic [3:0] REPEAT_MASK   = 4'b0011
) (
    input  logic       clk,
    input  logic       btn_reset,
    input  logic       enable,
    input  logic       dism_lvl,
    input  logic       aument_lvl,
    input  logic       derec_lvl,
    input  logic       izqda_lvl,
    input  logic       escrib_lvl,
    output logic       dism_p,
    output logic       aument_p,
    output logic       derec_p,
    output logic       izqda_p,
    output logic       escrib_p,
    output logic [2:0] active_key,
    output state_t     fsm_state
);

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t               state_q, state_n;
    key_t                 key_q, key_n;
    logic [CNT_W-1:0]     cnt_q, cnt_n;
    logic [NUM_KEYS-1:0]  nav_q, nav_n;

    logic [NUM_KEYS-1:0]  lvl;
    logic [NUM_KEYS-1:0]  key_mask;
    logic                 any_key;
    logic                 tracked_lvl;
    logic                 others_high;
    logic                 rpt_en;
    logic [CNT_W-1:0]     cnt_last;

    assign lvl         = {izqda_lvl, derec_lvl, aument_lvl, dism_lvl};
    assign key_mask    = key_onehot(key_q);
    assign any_key     = |lvl;
    assign tracked_lvl = |(lvl & key_mask);
    assign others_high = |(lvl & ~key_mask);
    assign rpt_en      = |(REPEAT_MASK & key_mask);
    assign cnt_last    = (state_q == HOLD) ? HOLD_LAST : REPEAT_LAST;

    always_ff @(posedge clk) begin
        if (!btn_reset) begin
            state_q <= IDLE;
            key_q   <= KEY_NONE;
            cnt_q   <= '0;
            nav_q   <= '0;
        end else begin
            state_q <= state_n;
            key_q   <= key_n;
            cnt_q   <= cnt_n;
            nav_q   <= nav_n;
        end
    end

    always_comb begin
        state_n = state_q;
        key_n   = key_q;
        cnt_n   = cnt_q;
        nav_n   = '0;
        case (state_q)
            IDLE: begin
                if (any_key) begin
                    if (enable) begin
                        key_n   = pick_key(lvl);
                        nav_n   = key_onehot(pick_key(lvl));
                        cnt_n   = '0;
                        state_n = HOLD;
                    end else begin
                        // Keys pressed while disabled must be fully released
                        // before they can generate anything.
                        state_n = WAIT_REL;
                    end
                end
            end
            HOLD, REPEAT: begin
                // Release and enable loss are checked before counter expiry
                // so that neither ever produces a pulse in the same cycle.
                if (!tracked_lvl) begin
                    key_n   = KEY_NONE;
                    cnt_n   = '0;
                    state_n = others_high ? WAIT_REL : IDLE;
                end else if (!enable) begin
                    key_n   = KEY_NONE;
                    cnt_n   = '0;
                    state_n = WAIT_REL;
                end else if (!rpt_en) begin
                    // Non-repeating key: count saturates instead of wrapping.
                    if (cnt_q != CNT_MAX) cnt_n = cnt_q + CNT_W'(1);
                end else if (cnt_q == cnt_last) begin
                    nav_n   = key_mask;
                    cnt_n   = '0;
                    state_n = REPEAT;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            WAIT_REL: begin
                if (!any_key) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                key_n   = KEY_NONE;
                cnt_n   = '0;
            end
        endcase
    end

    assign dism_p     = nav_q[0];
    assign aument_p   = nav_q[1];
    assign derec_p    = nav_q[2];
    assign izqda_p    = nav_q[3];
    assign active_key = key_q;
    assign fsm_state  = state_q;

    button_event_decoder_edge_pulse u_escrib_edge (
        .clk       (clk),
        .btn_reset (btn_reset),
        .lvl       (escrib_lvl),
        .pulse     (escrib_p)
    );

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Consumes the debounced button and switch levels from the input-conditioning stage of the RTC configuration path.
- Converts them into single-cycle command pulses for the configuration/write FSM.
- Navigation/value buttons produce one pulse per press, plus auto-repeat while held for selected keys.
- Write button produces one pulse per press, independent of the navigation keys.

Parameters:
- HOLD_CYCLES, 50000000, cycles from the initial press pulse to the first repeat pulse.
- REPEAT_CYCLES, 20000000, cycles between successive repeat pulses.
- CNT_W, 26, counter width; must hold max(HOLD_CYCLES, REPEAT_CYCLES).
- REPEAT_MASK, 4'b0011, per-key auto-repeat enable; bit0 dism, bit1 aument, bit2 derec, bit3 izqda.

Ports:
- clk  in  1  system clock
- btn_reset  in  1  synchronous, active-low reset
- enable  in  1  decoder enable (debounced sw_conf); low suppresses navigation pulses
- dism_lvl, aument_lvl, derec_lvl, izqda_lvl  in  1 each  debounced key levels, high = pressed
- escrib_lvl  in  1  debounced write-button level
- dism_p, aument_p, derec_p, izqda_p  out  1 each  one-cycle command pulses
- escrib_p  out  1  one-cycle write pulse
- active_key  out  3  tracked key: 0 none, 1 dism, 2 aument, 3 derec, 4 izqda

Behaviour:
- Reset and registers:
  - Clock and reset: single clock; btn_reset is synchronous and active-low.
  - All outputs are registered.
  - Reset value of every output, the counter and active_key is 0. FSM resets to IDLE. escrib_lvl history register resets to 0.
  - Reset mid-hold or mid-repeat aborts immediately, with no pulse in the reset cycle.
  - After release of reset, a key already held is treated as a new press only if the state is IDLE.
- Priority (simultaneous presses): dism > aument > derec > izqda. Only the highest-priority pressed key is tracked; the others are ignored.
- FSM states:
  - IDLE:
    - If enable=1 and any key is high, latch the winning key into active_key, assert its pulse in the next cycle, clear the counter, and go to HOLD.
    - If enable=0 and any key is high, go to WAIT_REL.
  - HOLD:
    - Counter increments each cycle.
    - If the tracked key is released: go to WAIT_REL if any other key is high, else IDLE.
    - If the tracked key's REPEAT_MASK bit is 0, stay in HOLD until release; the counter does not wrap.
    - Otherwise, when counter = HOLD_CYCLES-1: emit a pulse, clear the counter, and go to REPEAT.
  - REPEAT:
    - Same release rule as HOLD.
    - When counter = REPEAT_CYCLES-1: emit a pulse and clear the counter.
  - WAIT_REL: no pulses; go to IDLE only when all four key levels are 0.
- Timing and latency:
  - Latency: a key level first seen high at edge N in IDLE gives the pulse high during cycle N+1.
  - First repeat pulse is exactly HOLD_CYCLES cycles after the initial pulse.
  - Later repeat pulses are every REPEAT_CYCLES cycles.
- Release:
  - A release in the same cycle as counter expiry gives no pulse; release wins.
  - active_key returns to 0 in the cycle after leaving HOLD/REPEAT.
- enable dropping to 0 in HOLD or REPEAT: go to WAIT_REL immediately; no pulse in that cycle.
- A key switch (press B while A is held, then release A) never yields a B pulse until all keys are released.
- Write button:
  - escrib_p = escrib_lvl & ~escrib_prev, registered, so it goes high the cycle after the rising edge.
  - No repeat; it ignores enable and the FSM.
  - A held level gives exactly one pulse.
- Pulse exclusivity: at most one of the four navigation pulses is high in any cycle.

Decomposition:
- Shared package: FSM state encoding (IDLE, HOLD, REPEAT, WAIT_REL) and active_key codes (KEY_NONE..KEY_IZQDA).
  - The configuration FSM decodes active_key, so these codes belong in the package.
- One natural sub-module: edge_pulse, a registered rising-edge detector with sync active-low reset. Used for escrib_p and reusable elsewhere.
- The priority encoder and counter stay inline.

Test Plan (HOLD_CYCLES=8, REPEAT_CYCLES=4, REPEAT_MASK=4'b0011):
- Reset: btn_reset=0 for 3 cycles with all levels high -> all outputs 0 and active_key=0. After release with enable=1 -> dism_p single pulse one cycle later.
- Short press: aument_lvl high 5 cycles, enable=1 -> exactly one aument_p pulse, at cycle+1; active_key=2 then 0.
- Long press: dism_lvl high 30 cycles -> pulses at relative cycles 1, 9, 13, 17, 21, 25, 29 (7 pulses); none after release.
- No-repeat key and priority:
  - derec_lvl and izqda_lvl rise in the same cycle and are held 20 cycles -> one derec_p only; izqda_p never.
  - Release derec while izqda is still held -> no pulse; izqda_p only after both are released and izqda is pressed again.
- enable and write button:
  - enable=0 while aument is held -> zero pulses.
  - enable dropped mid-repeat -> pulses stop that cycle; no new pulse until all keys are released.
  - escrib_lvl held 10 cycles -> exactly one escrib_p.
